// File: rtl/rstvec_pkg.sv
// Shared definitions for the reset-vector readout master and its benches.
// Contents: FSM state enum, default geometry constants, the phase counter
// width, the reset-vector default pattern, and the result payload struct.
package rstvec_pkg;

   localparam int unsigned RSTVEC_ADDR_N = 19;
   localparam int unsigned RSTVEC_IDX_N  = 5;
   localparam int unsigned RSTVEC_NDIB   = 10;

   // Phase counter width; covers the legal WAIT range 1..15.
   localparam int unsigned RSTVEC_CNT_N  = 4;

   // Reset address the bench prober models present by default.
   localparam logic [RSTVEC_ADDR_N-1:0] RSTVEC_DEFAULT = 19'h4BEEF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_FALL,
      ST_SAMPLE,
      ST_DONE
   } rstvec_state_e;

   // Result payload as seen by the board controller.
   typedef struct packed {
      logic                     err;
      logic [RSTVEC_ADDR_N-1:0] addr;
   } rstvec_result_t;

endpackage

// File: rtl/rstvec_readout_master_if.sv
// Readout master bus: host-side request/result signals plus the prober-side
// dibble readout port.
// Signals:
//   i_start          host -> master : request a transaction
//   o_busy, o_valid  master -> host : status / one-cycle result strobe
//   o_addr, o_err    master -> host : reassembled address and error flag
//   o_pclk, o_idx    master -> prober : readout clock and dibble index
//   i_dat            prober -> master : dibble data
// Modports: master (the readout master), slave (host + prober environment).
interface rstvec_readout_master_if #(
   parameter int unsigned ADDR_N = 19,
   parameter int unsigned IDX_N  = 5
);

   logic              i_start;
   logic              o_busy;
   logic              o_valid;
   logic [ADDR_N-1:0] o_addr;
   logic              o_err;
   logic              o_pclk;
   logic [IDX_N-1:0]  o_idx;
   logic [1:0]        i_dat;

   modport master (
      input  i_start,
      input  i_dat,
      output o_busy,
      output o_valid,
      output o_addr,
      output o_err,
      output o_pclk,
      output o_idx
   );

   modport slave (
      output i_start,
      output i_dat,
      input  o_busy,
      input  o_valid,
      input  o_addr,
      input  o_err,
      input  o_pclk,
      input  o_idx
   );

endinterface

// File: rtl/rstvec_phase_timer.sv
// Loadable down-counter timing one readout-clock phase of WAIT cycles.
// Ports:
//   clk     in  system clock
//   rst     in  synchronous active-high reset
//   load    in  start a new phase (counter <= WAIT-1)
//   done_c  out combinational: current cycle is the last of the phase
module rstvec_phase_timer
   import rstvec_pkg::*;
#(
   parameter int unsigned WAIT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic done_c
);

   localparam int unsigned CNT_N = RSTVEC_CNT_N;

   logic [CNT_N-1:0] cnt;

   // Loaded with WAIT-1 so the loaded value itself counts as the first cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CNT_N'(WAIT - 1);
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_N'(1);
      end
   end

   assign done_c = (cnt == '0);

endmodule

// File: rtl/rstvec_readout_master.sv
// Host-side reader for the reset-vector prober's dibble readout port.
// Drives the prober's readout clock and dibble index, samples 2-bit data
// after each falling edge, reassembles the reset address and presents it
// with a one-cycle valid strobe.
// Ports:
//   i_clk  in  system clock (posedge)
//   i_rst  in  synchronous active-high reset
//   bus    rstvec_readout_master_if.master (i_start, o_busy, o_valid,
//          o_addr, o_err, o_pclk, o_idx, i_dat)
// Build option: RSTVEC_DBLREAD_EN reads every dibble twice and flags any
//   disagreement between the two reads in o_err.
module rstvec_readout_master
   import rstvec_pkg::*;
#(
   parameter int unsigned ADDR_N = RSTVEC_ADDR_N,
   parameter int unsigned IDX_N  = RSTVEC_IDX_N,
   parameter int unsigned WAIT   = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   rstvec_readout_master_if.master  bus
);

   localparam int unsigned NDIB    = (ADDR_N + 1) / 2;
   localparam int unsigned SHIFT_N = 2 * NDIB;

   rstvec_state_e      state;
   logic [IDX_N-1:0]   idx;
   logic [SHIFT_N-1:0] shift;
   logic               err_acc;
   logic               last_c;
   logic               finish_c;
   logic               advance_c;
   logic               load_c;
   logic               phase_done_c;

`ifdef RSTVEC_DBLREAD_EN
   logic               pass;
   logic [1:0]         first;

   // Second read of each index is the one that moves on.
   assign advance_c = pass;
`else
   assign advance_c = 1'b1;
`endif

   assign last_c   = (idx == IDX_N'(NDIB - 1));
   assign finish_c = last_c & advance_c;

   // Restart the phase timer on every transition into SETUP or FALL.
   assign load_c = ((state == ST_IDLE)   & bus.i_start)
                 | ((state == ST_SETUP)  & phase_done_c)
                 | ((state == ST_SAMPLE) & ~finish_c);

   rstvec_phase_timer #(
      .WAIT (WAIT)
   ) u_timer (
      .clk    (i_clk),
      .rst    (i_rst),
      .load   (load_c),
      .done_c (phase_done_c)
   );

   assign bus.o_idx = idx;

   // Transaction FSM with registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= ST_IDLE;
         idx         <= '0;
         shift       <= '0;
         err_acc     <= 1'b0;
         bus.o_pclk  <= 1'b1;
         bus.o_busy  <= 1'b0;
         bus.o_valid <= 1'b0;
         bus.o_addr  <= '0;
         bus.o_err   <= 1'b0;
`ifdef RSTVEC_DBLREAD_EN
         pass        <= 1'b0;
         first       <= 2'b00;
`endif
      end else begin
         bus.o_valid <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               bus.o_pclk <= 1'b1;
               if (bus.i_start) begin
                  state      <= ST_SETUP;
                  idx        <= '0;
                  shift      <= '0;
                  err_acc    <= 1'b0;
                  bus.o_busy <= 1'b1;
`ifdef RSTVEC_DBLREAD_EN
                  pass       <= 1'b0;
`endif
               end
            end
            ST_SETUP: begin
               if (phase_done_c) begin
                  state      <= ST_FALL;
                  bus.o_pclk <= 1'b0;
               end
            end
            ST_FALL: begin
               if (phase_done_c) begin
                  state <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               for (int unsigned d = 0; d < NDIB; d++) begin
                  if (idx == IDX_N'(d)) begin
                     shift[2*d +: 2] <= bus.i_dat;
                  end
               end
`ifdef RSTVEC_DBLREAD_EN
               if (pass) begin
                  if (first != bus.i_dat) begin
                     err_acc <= 1'b1;
                  end
               end else begin
                  first <= bus.i_dat;
               end
               pass <= ~pass;
`endif
               bus.o_pclk <= 1'b1;
               if (finish_c) begin
                  state <= ST_DONE;
               end else begin
                  state <= ST_SETUP;
                  if (advance_c) begin
                     idx <= idx + IDX_N'(1);
                  end
               end
            end
            ST_DONE: begin
               // Top bit of the last dibble lies beyond the address and must be 0.
               bus.o_addr  <= shift[ADDR_N-1:0];
               bus.o_err   <= err_acc | shift[ADDR_N];
               bus.o_valid <= 1'b1;
               bus.o_busy  <= 1'b0;
               bus.o_pclk  <= 1'b1;
               state       <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rstvec_readout_master.sv
// Self-checking bench for rstvec_readout_master: two instances (WAIT=2 and
// WAIT=1), each driven by a behavioural prober that returns dibbles of a
// 20-bit word on falling edges of o_pclk. Honours RSTVEC_DBLREAD_EN.
module tb_rstvec_readout_master;
   import rstvec_pkg::*;

   localparam int unsigned ADDR_N = RSTVEC_ADDR_N;
   localparam int unsigned IDX_N  = RSTVEC_IDX_N;
   localparam int unsigned NDIB   = RSTVEC_NDIB;
`ifdef RSTVEC_DBLREAD_EN
   localparam int unsigned READS  = 2;
`else
   localparam int unsigned READS  = 1;
`endif
   localparam int LAT_A = int'(NDIB * READS * (2 * 2 + 1) + 1);
   localparam int LAT_B = int'(NDIB * READS * (2 * 1 + 1) + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   rstvec_readout_master_if #(.ADDR_N(ADDR_N), .IDX_N(IDX_N)) bus_a ();
   rstvec_readout_master_if #(.ADDR_N(ADDR_N), .IDX_N(IDX_N)) bus_b ();

   rstvec_readout_master #(.ADDR_N(ADDR_N), .IDX_N(IDX_N), .WAIT(2)) dut_a (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus_a.master)
   );

   rstvec_readout_master #(.ADDR_N(ADDR_N), .IDX_N(IDX_N), .WAIT(1)) dut_b (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus_b.master)
   );

   always #5 clk = ~clk;

   // Prober models: present the addressed dibble after each falling edge.
   logic [19:0] word_a = 20'h0;
   logic [19:0] word_b = 20'h0;
   bit          flip_a = 1'b0;
   int          reads3_a = 0;
   int          idx_log_a[$];
   bit          oob = 1'b0;

   initial begin
      bus_a.i_start = 1'b0;
      bus_a.i_dat   = 2'b00;
      bus_b.i_start = 1'b0;
      bus_b.i_dat   = 2'b00;
   end

   always @(negedge bus_a.o_pclk) begin : prober_a
      int         i;
      logic [1:0] d;
      i = int'(bus_a.o_idx);
      idx_log_a.push_back(i);
      d = 2'(word_a >> (2 * i));
      if (i == 3) begin
         if (flip_a && reads3_a == 1) d = d ^ 2'b01;
         reads3_a++;
      end
      bus_a.i_dat = d;
   end

   always @(negedge bus_b.o_pclk) begin : prober_b
      bus_b.i_dat = 2'(word_b >> (2 * int'(bus_b.o_idx)));
   end

   always @(posedge clk) begin
      if (int'(bus_a.o_idx) > int'(NDIB - 1) || int'(bus_b.o_idx) > int'(NDIB - 1)) oob = 1'b1;
   end

   // One transaction on instance A; returns latency (0 on timeout) and result.
   task automatic txn_a(input logic [19:0] w, input bit flip, output int lat,
                        output logic [18:0] addr, output logic err,
                        output int extra_valids, output int busy_bad);
      word_a = w; flip_a = flip; reads3_a = 0; idx_log_a.delete();
      busy_bad = 0; lat = 0; addr = '0; err = 1'b0; extra_valids = 0;
      @(posedge clk); #1 bus_a.i_start = 1'b1;
      @(posedge clk); #1 bus_a.i_start = 1'b0;
      if (!bus_a.o_busy) busy_bad++;
      for (int n = 1; n <= 500; n++) begin
         @(posedge clk); #1;
         if (bus_a.o_valid) begin
            lat = n; addr = bus_a.o_addr; err = bus_a.o_err;
            break;
         end
         if (!bus_a.o_busy) busy_bad++;
      end
      repeat (40) begin
         @(posedge clk); #1;
         if (bus_a.o_valid) extra_valids++;
      end
   endtask

   task automatic txn_b(input logic [19:0] w, output int lat, output logic [18:0] addr);
      word_b = w; lat = 0; addr = '0;
      @(posedge clk); #1 bus_b.i_start = 1'b1;
      @(posedge clk); #1 bus_b.i_start = 1'b0;
      for (int n = 1; n <= 500; n++) begin
         @(posedge clk); #1;
         if (bus_b.o_valid) begin
            lat = n; addr = bus_b.o_addr;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus_a.o_pclk !== 1'b1) begin errors++; $display("FAIL reset_pclk: got %b want 1", bus_a.o_pclk); end
      checks++; if (bus_a.o_idx !== '0) begin errors++; $display("FAIL reset_idx: got %0d want 0", bus_a.o_idx); end
      checks++; if (bus_a.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus_a.o_busy); end
      checks++; if (bus_a.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus_a.o_valid); end
      checks++; if (bus_a.o_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus_a.o_addr); end
      checks++; if (bus_a.o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus_a.o_err); end
      rst = 1'b0;
   endtask

   task automatic test_basic;
      int lat, extra, bb, seq_bad;
      logic [18:0] addr;
      logic err;
      txn_a({1'b0, RSTVEC_DEFAULT}, 1'b0, lat, addr, err, extra, bb);
      checks++; if (lat != LAT_A) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT_A); end
      checks++; if (addr !== RSTVEC_DEFAULT) begin errors++; $display("FAIL basic_addr: got %h want %h", addr, RSTVEC_DEFAULT); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", err); end
      checks++; if (extra != 0) begin errors++; $display("FAIL basic_single_valid: got %0d extra strobes want 0", extra); end
      checks++; if (bb != 0) begin errors++; $display("FAIL basic_busy: got %0d idle cycles want 0", bb); end
      checks++; if (idx_log_a.size() != int'(NDIB * READS)) begin errors++; $display("FAIL basic_pclk_falls: got %0d want %0d", idx_log_a.size(), NDIB * READS); end
      seq_bad = 0;
      foreach (idx_log_a[k]) if (idx_log_a[k] != k / int'(READS)) seq_bad++;
      checks++; if (seq_bad != 0) begin errors++; $display("FAIL basic_idx_seq: got %0d out-of-order indices want 0", seq_bad); end
   endtask

   task automatic test_err_bit;
      int lat, extra, bb;
      logic [18:0] addr;
      logic err;
      txn_a(20'hFFFFF, 1'b0, lat, addr, err, extra, bb);
      checks++; if (addr !== 19'h7FFFF) begin errors++; $display("FAIL errbit_addr: got %h want 7ffff", addr); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL errbit_err: got %b want 1", err); end
   endtask

   task automatic test_random;
      int lat, extra, bb;
      logic [18:0] addr;
      logic err;
      logic [19:0] w;
      for (int r = 0; r < 4; r++) begin
         w = 20'($urandom);
         txn_a(w, 1'b0, lat, addr, err, extra, bb);
         checks++; if (addr !== w[18:0]) begin errors++; $display("FAIL random_addr[%0d]: got %h want %h", r, addr, w[18:0]); end
         checks++; if (err !== w[19]) begin errors++; $display("FAIL random_err[%0d]: got %b want %b", r, err, w[19]); end
      end
   endtask

   task automatic test_back_to_back;
      int t[3];
      int nv;
      int cyc;
      logic [18:0] a[3];
      word_a = {1'b0, RSTVEC_DEFAULT}; flip_a = 1'b0;
      nv = 0; cyc = 0;
      @(posedge clk); #1 bus_a.i_start = 1'b1;
      while (nv < 3 && cyc < 1000) begin
         @(posedge clk); #1; cyc++;
         if (bus_a.o_valid) begin
            t[nv] = cyc; a[nv] = bus_a.o_addr; nv++;
         end
      end
      bus_a.i_start = 1'b0;
      checks++; if (nv != 3) begin errors++; $display("FAIL b2b_count: got %0d strobes want 3", nv); end
      if (nv == 3) begin
         checks++; if (t[1] - t[0] != LAT_A + 1) begin errors++; $display("FAIL b2b_gap1: got %0d want %0d", t[1] - t[0], LAT_A + 1); end
         checks++; if (t[2] - t[1] != LAT_A + 1) begin errors++; $display("FAIL b2b_gap2: got %0d want %0d", t[2] - t[1], LAT_A + 1); end
         checks++; if (a[2] !== RSTVEC_DEFAULT) begin errors++; $display("FAIL b2b_addr: got %h want %h", a[2], RSTVEC_DEFAULT); end
      end
      repeat (5) @(posedge clk);
      #1;
      checks++; if (bus_a.o_busy !== 1'b0) begin errors++; $display("FAIL b2b_drain: got busy %b want 0", bus_a.o_busy); end
   endtask

   task automatic test_mid_reset;
      int lat, extra, bb, nv;
      bit hit;
      logic [18:0] addr;
      logic err;
      word_a = {1'b0, RSTVEC_DEFAULT}; flip_a = 1'b0; reads3_a = 0;
      @(posedge clk); #1 bus_a.i_start = 1'b1;
      @(posedge clk); #1 bus_a.i_start = 1'b0;
      hit = 1'b0;
      for (int n = 0; n < 500; n++) begin
         if (bus_a.o_idx == IDX_N'(4) && bus_a.o_pclk == 1'b0) begin hit = 1'b1; break; end
         @(posedge clk); #1;
      end
      checks++; if (!hit) begin errors++; $display("FAIL midrst_reach_idx4: got timeout want idx 4 fall"); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (bus_a.o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus_a.o_busy); end
      checks++; if (bus_a.o_pclk !== 1'b1) begin errors++; $display("FAIL midrst_pclk: got %b want 1", bus_a.o_pclk); end
      checks++; if (bus_a.o_idx !== '0) begin errors++; $display("FAIL midrst_idx: got %0d want 0", bus_a.o_idx); end
      checks++; if (bus_a.o_addr !== '0) begin errors++; $display("FAIL midrst_addr: got %h want 0", bus_a.o_addr); end
      nv = 0;
      repeat (150) begin
         @(posedge clk); #1;
         if (bus_a.o_valid) nv++;
      end
      checks++; if (nv != 0) begin errors++; $display("FAIL midrst_no_valid: got %0d strobes want 0", nv); end
      txn_a({1'b0, RSTVEC_DEFAULT}, 1'b0, lat, addr, err, extra, bb);
      checks++; if (addr !== RSTVEC_DEFAULT) begin errors++; $display("FAIL midrst_reread_addr: got %h want %h", addr, RSTVEC_DEFAULT); end
      checks++; if (lat != LAT_A) begin errors++; $display("FAIL midrst_reread_lat: got %0d want %0d", lat, LAT_A); end
   endtask

   task automatic test_wait1;
      int lat;
      logic [18:0] addr;
      logic [19:0] w;
      txn_b(20'h00001, lat, addr);
      checks++; if (lat != LAT_B) begin errors++; $display("FAIL wait1_latency: got %0d want %0d", lat, LAT_B); end
      checks++; if (addr !== 19'h00001) begin errors++; $display("FAIL wait1_addr: got %h want 00001", addr); end
      w = {1'b0, 19'($urandom)};
      txn_b(w, lat, addr);
      checks++; if (addr !== w[18:0]) begin errors++; $display("FAIL wait1_rand_addr: got %h want %h", addr, w[18:0]); end
   endtask

   task automatic test_dblread;
      int lat, extra, bb;
      logic [18:0] addr;
      logic err;
      logic [19:0] w;
      logic [19:0] exp_w;
      logic exp_err;
      // A flipped second read of index 3 only exists when each index is read twice.
      w       = {1'b0, RSTVEC_DEFAULT};
      exp_w   = (READS == 2) ? (w ^ 20'h00040) : w;
      exp_err = (READS == 2);
      txn_a(w, 1'b1, lat, addr, err, extra, bb);
      checks++; if (err !== exp_err) begin errors++; $display("FAIL dbl_flip_err: got %b want %b", err, exp_err); end
      checks++; if (addr !== exp_w[18:0]) begin errors++; $display("FAIL dbl_flip_addr: got %h want %h", addr, exp_w[18:0]); end
      checks++; if (lat != LAT_A) begin errors++; $display("FAIL dbl_flip_latency: got %0d want %0d", lat, LAT_A); end
      txn_a(w, 1'b0, lat, addr, err, extra, bb);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL dbl_stable_err: got %b want 0", err); end
      checks++; if (addr !== RSTVEC_DEFAULT) begin errors++; $display("FAIL dbl_stable_addr: got %h want %h", addr, RSTVEC_DEFAULT); end
   endtask

   task automatic test_idx_range;
      checks++; if (oob) begin errors++; $display("FAIL idx_range: got index above %0d want none", NDIB - 1); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_err_bit();
      test_random();
      test_back_to_back();
      test_mid_reset();
      test_wait1();
      test_dblread();
      test_idx_range();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/rstvec_readout_master.md
Name: rstvec_readout_master

Overview:
- Host-side reader for the reset-vector prober's dibble readout port.
- Generates the prober's readout clock and 5-bit dibble index, and samples the 2-bit readout data.
- Reassembles the captured 19-bit CPU reset address and presents it with a one-cycle valid strobe.
- Sits between the prober and the board controller / debug register file.

Parameters:
- ADDR_N, 19: width of the reassembled address.
- IDX_N, 5: width of the dibble index driven to the prober.
- WAIT, 2: system-clock cycles per readout-clock phase; legal range 1..15.
- NDIB (localparam), (ADDR_N+1)/2 = 10: dibbles per transaction.

Ports:
- i_clk  in  1  system clock; all logic on posedge.
- i_rst  in  1  synchronous active-high reset.
- i_start  in  1  request a readout transaction; sampled only in IDLE.
- o_busy  out  1  transaction in progress.
- o_valid  out  1  one-cycle strobe: o_addr/o_err are valid.
- o_addr  out  ADDR_N  reassembled reset address, held until the next valid.
- o_err  out  1  transaction error flag, held with o_addr.
- o_pclk  out  1  readout clock to the prober; the prober updates its data on the falling edge.
- o_idx  out  IDX_N  dibble index to the prober.
- i_dat  in  2  dibble data from the prober.

Behaviour:
- Reset values: o_pclk=1, o_idx=0, o_busy=0, o_valid=0, o_addr=0, o_err=0, FSM=IDLE, phase counter=0, shift register=0.
- FSM states: IDLE, SETUP, FALL, SAMPLE, DONE.
- IDLE:
  - o_pclk=1.
  - i_start=1 → SETUP next cycle; o_idx=0, o_busy=1, clear the shift register and error accumulator.
- SETUP:
  - o_pclk=1; o_idx stable.
  - Hold WAIT cycles, then → FALL.
- FALL:
  - o_pclk=0 (the prober sees its falling edge); hold WAIT cycles, then → SAMPLE.
- SAMPLE (1 cycle):
  - o_pclk stays 0.
  - Capture i_dat into bits [2*idx+1 : 2*idx] of the 20-bit shift register.
  - If idx==NDIB-1 → DONE; else idx+1 → SETUP (o_pclk returns to 1).
- DONE (1 cycle):
  - o_addr = shift[ADDR_N-1:0]; o_valid=1; o_busy=0; o_pclk=1.
  - o_err = accumulated error OR shift[ADDR_N] (index 9 high bit must read 0).
  - → IDLE.
- Latency: o_valid is high exactly NDIB*(2*WAIT+1)+1 cycles after the start-accept edge (51 for the defaults).
- Transaction rules:
  - i_start while busy is ignored, not queued.
  - i_start high in the DONE cycle is ignored; it is honoured the next cycle in IDLE.
- Reset mid-transaction: next cycle returns to the reset values above. o_valid is not asserted and o_addr is cleared.
- o_idx never exceeds NDIB-1; indices NDIB..31 are never driven.
- WAIT=1: minimum legal timing. SETUP and FALL are one cycle each; no zero-length phases.

Optional Feature:
- Macro: RSTVEC_DBLREAD_EN.
- Defined:
  - Each index runs SETUP/FALL/SAMPLE twice. Both samples are compared.
  - A mismatch sets the error accumulator. The second sample is stored.
  - Latency becomes NDIB*2*(2*WAIT+1)+1 cycles (101 for the defaults).
- Undefined:
  - Single read per index.
  - Only the index 9 high-bit check feeds o_err.

Decomposition:
- Shared package rstvec_pkg holds:
  - the FSM state enum;
  - RSTVEC_ADDR_N=19, RSTVEC_IDX_N=5, RSTVEC_NDIB=10;
  - the reset-vector default pattern 19'h4BEEF used by benches.
- One sub-module, rstvec_phase_timer: loadable down-counter generating the WAIT-cycle phase-done pulse.

Test Plan:
- Prober model capturing 19'h4BEEF, pulse i_start → exactly one o_valid, 51 cycles later; o_addr=19'h4BEEF, o_err=0; o_idx sequence 0..9, ten o_pclk falling edges.
- Prober model driving 2'b11 for index 9 (bit 19 set), address 19'h7FFFF → o_addr=19'h7FFFF, o_err=1.
- i_start held high continuously → back-to-back transactions; valid strobes 52 cycles apart; no start accepted while o_busy=1.
- i_rst asserted during index 4 FALL → next cycle o_busy=0, o_pclk=1, o_idx=0, o_addr=0; no o_valid. A following start reads 19'h4BEEF correctly.
- WAIT=1 build, address 19'h00001 → o_valid after 31 cycles, o_addr=19'h00001.
- RSTVEC_DBLREAD_EN, model flipping index 3 data between its two reads → o_err=1, latency 101; with a stable model, o_err=0.
